// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, stalling the pipeline until the result is ready.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       func3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StMulRun = 2'd1;
   localparam logic [1:0] StDivRun = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   localparam logic [2:0] F3Mul   = 3'b000;
   localparam logic [2:0] F3Mulhu = 3'b011;
   localparam logic [2:0] F3Divu  = 3'b101;
   localparam logic [2:0] F3Remu  = 3'b111;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;
   logic               div_fits;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quot_step;
   logic               accept;

   // Multiply step: add into the upper WIDTH+1 bits, then shift the whole accumulator right.
   always_comb begin
      mul_addend = mplier_q[0] ? mcand_q : '0;
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
      acc_step   = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Restoring divide step, compared on WIDTH+1 bits so the shifted remainder cannot overflow.
   always_comb begin
      rem_sh    = {rem_q, quot_q[WIDTH-1]};
      rem_diff  = rem_sh - {1'b0, divisor_q};
      div_fits  = ~rem_diff[WIDTH];
      rem_step  = div_fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], div_fits};
   end

   assign accept = start && ((state_q == StIdle) || (state_q == StDone));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      result_d  = result_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               op_d  = func3;
               cnt_d = '0;
               case (func3)
                  F3Mul, F3Mulhu: begin
                     mcand_d  = op_a;
                     mplier_d = op_b;
                     acc_d    = '0;
                     state_d  = StMulRun;
                  end
                  F3Divu, F3Remu: begin
                     if (op_b != '0) begin
                        quot_d    = op_a;
                        rem_d     = '0;
                        divisor_d = op_b;
                        state_d   = StDivRun;
                     end else begin
                        // RISC-V divide-by-zero: quotient all ones, remainder is the dividend.
                        result_d = (func3 == F3Divu) ? '1 : op_a;
                        state_d  = StDone;
                     end
                  end
                  default: begin
                     result_d = '0;
                     state_d  = StDone;
                  end
               endcase
            end else begin
               state_d = StIdle;
            end
         end
         StMulRun: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) begin
               result_d = (op_q == F3Mulhu) ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
               state_d  = StDone;
            end
         end
         StDivRun: begin
            rem_d  = rem_step;
            quot_d = quot_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) begin
               result_d = (op_q == F3Remu) ? rem_step : quot_step;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q == StMulRun) || (state_q == StDivRun);
   assign stall  = busy || accept;
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, multi-cycle corner sequences and a
// randomized sweep against an arithmetic reference model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  func3 = 3'b000;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .func3  (func3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [7:0]  lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (f3)
         3'b000:  return p[31:0];
         3'b011:  return p[63:32];
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b111:  return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] b);
      if (f3 == 3'b000 || f3 == 3'b011) return 33;
      if ((f3 == 3'b101 || f3 == 3'b111) && b != 0) return 33;
      return 1;
   endfunction

   // Called at posedge+1 with the DUT in IDLE or DONE; returns with done visible.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_seen,
                         output bit stall_ok);
      start = 1'b1;
      func3 = f3;
      op_a  = a;
      op_b  = b;
      #1;
      stall_ok  = stall;
      busy_seen = 1'b0;
      lat       = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      func3 = 3'($urandom);
      op_a  = $urandom;
      op_b  = $urandom;
      lat   = 1;
      #1;
      while (!done && lat < 100) begin
         busy_seen |= busy;
         if (!stall) stall_ok = 1'b0;
         @(posedge clk);
         #2;
         lat++;
      end
      busy_seen |= busy;
      if (stall) stall_ok = 1'b0;
      res = result;
      @(negedge clk);
      #0;
      @(posedge clk);
      // Leave the DUT in the DONE cycle's following edge undecided: back off to DONE timing.
   endtask

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t        vecs[12];
   logic [31:0] res;
   int          lat;
   bit          busy_seen;
   bit          stall_ok;
   int          cyc;
   int          done_cnt;

   initial begin
      vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         8'd33};
      vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  8'd33};
      vecs[2]  = '{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  8'd33};
      vecs[3]  = '{3'b101, 32'd100,        32'd7,          32'd14,         8'd33};
      vecs[4]  = '{3'b111, 32'd100,        32'd7,          32'd2,          8'd33};
      vecs[5]  = '{3'b101, 32'd100,        32'd0,          32'hFFFF_FFFF,  8'd1};
      vecs[6]  = '{3'b111, 32'h1234,       32'd0,          32'h1234,       8'd1};
      vecs[7]  = '{3'b010, 32'd55,         32'd3,          32'd0,          8'd1};
      vecs[8]  = '{3'b101, 32'd5,          32'd10,         32'd0,          8'd33};
      vecs[9]  = '{3'b111, 32'd5,          32'd10,         32'd5,          8'd33};
      vecs[10] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  8'd33};
      vecs[11] = '{3'b011, 32'h8000_0000,  32'd4,          32'd2,          8'd33};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_stall_idle", {31'd0, stall}, 32'd0);
      start = 1'b1;
      #1;
      check("reset_stall_start", {31'd0, stall}, 32'd1);
      start = 1'b0;
      rst   = 1'b0;
      wait_cycle();

      // Directed table
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) wait_cycle();
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, busy_seen, stall_ok);
         #1;
         check($sformatf("vec%0d_result", i), res, vecs[i].res);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_busy", i), {31'd0, busy_seen}, {31'd0, vecs[i].lat != 8'd1});
         check($sformatf("vec%0d_stall", i), {31'd0, stall_ok}, 32'd1);
         check($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
      end
      wait_cycle();

      // Back-to-back: REMU accepted in the DONE cycle of a DIVU
      run_op(3'b101, 32'd100, 32'd7, res, lat, busy_seen, stall_ok);
      #1;
      check("b2b_divu_result", res, 32'd14);
      wait_cycle();
      start = 1'b1;
      func3 = 3'b101;
      op_a  = 32'd100;
      op_b  = 32'd7;
      cyc   = 1;
      wait_cycle();
      start = 1'b0;
      while (!done && cyc < 100) begin
         wait_cycle();
         cyc++;
      end
      check("b2b_first_latency", 32'(cyc), 32'd33);
      start = 1'b1;
      func3 = 3'b111;
      #1;
      check("b2b_stall_in_done", {31'd0, stall}, 32'd1);
      wait_cycle();
      start = 1'b0;
      #1;
      check("b2b_no_bubble_busy", {31'd0, busy}, 32'd1);
      check("b2b_result_held", result, 32'd14);
      cyc = 1;
      while (!done && cyc < 100) begin
         wait_cycle();
         cyc++;
      end
      #1;
      check("b2b_second_latency", 32'(cyc), 32'd33);
      check("b2b_remu_result", result, 32'd2);
      wait_cycle();

      // start while busy is ignored
      start = 1'b1;
      func3 = 3'b000;
      op_a  = 32'd7;
      op_b  = 32'd6;
      wait_cycle();
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 100) begin
         if (cyc == 10) begin
            start = 1'b1;
            func3 = 3'b101;
            op_a  = 32'd99;
            op_b  = 32'd3;
         end else begin
            start = 1'b0;
         end
         wait_cycle();
         cyc++;
      end
      start = 1'b0;
      #1;
      check("ignore_latency", 32'(cyc), 32'd33);
      check("ignore_result", result, 32'd42);
      wait_cycle();

      // Reset mid-operation
      start = 1'b1;
      func3 = 3'b000;
      op_a  = 32'd9;
      op_b  = 32'd9;
      wait_cycle();
      start = 1'b0;
      for (int c = 1; c < 20; c++) wait_cycle();
      #1;
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      wait_cycle();
      rst = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) done_cnt++;
         wait_cycle();
      end
      check("abort_no_done_pulse", 32'(done_cnt), 32'd0);

      // Random sweep
      for (int i = 0; i < 1000; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] b;
         case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b011;
            2: f3 = 3'b101;
            3: f3 = 3'b111;
            default: f3 = 3'($urandom);
         endcase
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(0, 15));
            1: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) wait_cycle();
         run_op(f3, a, b, res, lat, busy_seen, stall_ok);
         #1;
         check($sformatf("rand%0d_f3=%b_a=%h_b=%h_result", i, f3, a, b), res,
               ref_result(f3, a, b));
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(f3, b)));
         check($sformatf("rand%0d_stall", i), {31'd0, stall_ok}, 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
